// File: rtl/ifu_prefetch_if.sv
// Signal bundle between the fetch unit and its environment (instruction memory, decode, control).
// The master modport is the fetch unit's view; slave is the surrounding system.
interface ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            fetch_en;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] inst_o;
  logic            fetch_busy;

  modport master (
    input  fetch_en, redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, if_valid, pc_o, inst_o, fetch_busy
  );

  modport slave (
    output fetch_en, redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, if_valid, pc_o, inst_o, fetch_busy
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: issues fetch requests under a FIFO credit limit,
// buffers in-order responses with their PCs, and discards stale responses after a redirect.
module ifu_prefetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4,
  parameter int              PC_STEP    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ifu_prefetch_if.master bus
);
  localparam int              AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW    = AW + 1;
  localparam int              SB    = $clog2(PC_STEP);
  localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN = {XLEN{1'b1}} << SB;
  localparam logic [CW:0]     DEPTH = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [XLEN-1:0] inst_mem_q [FIFO_DEPTH];

  logic          req_valid, fire, out_valid, pop, push;
  logic [CW:0]   occ, pend, redir_drop;
  logic [XLEN-1:0] redir_pc;

  always_comb begin
    occ        = {1'b0, count_q} + {1'b0, live_q};
    pend       = {1'b0, live_q} + {1'b0, drop_q};
    req_valid  = bus.fetch_en & ~bus.redirect & (occ < DEPTH);
    fire       = req_valid & bus.imem_req_ready;
    out_valid  = (count_q != '0) & ~bus.redirect;
    pop        = out_valid & bus.id_ready;
    push       = bus.imem_rsp_valid & ~bus.redirect & (drop_q == '0) & (live_q != '0);
    redir_pc   = bus.redirect_pc & ALIGN;
    redir_drop = pend;
    if (bus.imem_rsp_valid && (pend != '0)) begin
      redir_drop = pend - 1'b1;
    end

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    live_d     = live_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (bus.redirect) begin
      // Everything in flight becomes stale; a response landing this cycle retires one of them.
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      count_d    = '0;
      live_d     = '0;
      drop_d     = redir_drop[CW-1:0];
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + STEP;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (bus.imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      live_d  = live_q + CW'(fire) - CW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      live_q     <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        inst_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = out_valid;
  assign bus.pc_o           = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.inst_o         = out_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.fetch_busy     = (pend != '0);
endmodule
